// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline stall/flush/run controller.
// State codes are visible on the debug port, so their values are fixed.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  // pipeline-register indices (register k sits between stage k and k+1)
  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Debug/request and pipeline-control bundle for pipeline_ctrl.
// master = debug unit / datapath side, slave = the controller.
interface pipeline_ctrl_if #(
  parameter int NUM_STAGES    = 5,
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_WIDTH     = 32
);
  logic                     run_req;
  logic                     step_req;
  logic                     halt_req;
  logic                     halt_instr;
  logic                     ex_mem_read;
  logic [REG_ADDR_BITS-1:0] ex_rt_addr;
  logic [REG_ADDR_BITS-1:0] id_rs_addr;
  logic [REG_ADDR_BITS-1:0] id_rt_addr;
  logic                     branch_taken;
  logic                     pc_enable;
  logic [NUM_STAGES-2:0]    stage_enable;
  logic [NUM_STAGES-2:0]    stage_flush;
  logic [1:0]               state;
  logic [CNT_WIDTH-1:0]     cycle_count;
  logic [CNT_WIDTH-1:0]     stall_count;

  modport master (
    output run_req, step_req, halt_req, halt_instr, ex_mem_read,
           ex_rt_addr, id_rs_addr, id_rt_addr, branch_taken,
    input  pc_enable, stage_enable, stage_flush, state,
           cycle_count, stall_count
  );

  modport slave (
    input  run_req, step_req, halt_req, halt_instr, ex_mem_read,
           ex_rt_addr, id_rs_addr, id_rt_addr, branch_taken,
    output pc_enable, stage_enable, stage_flush, state,
           cycle_count, stall_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction in ID. Register 0 is hardwired zero and never hazards.
module hazard_detect #(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
  output logic                     hazard
);
  assign hazard = mem_read && (ex_rt_addr != '0) &&
                  ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer plus stall/flush mask generation for an
// N-stage pipeline, with saturating cycle and stall counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int BRANCH_STAGE  = 3,
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_WIDTH     = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);
  localparam int NREG = NUM_STAGES - 1;

  state_t state_q, state_d;
  logic   hazard, advance, stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run_req)       state_d = ST_RUN;
        else if (bus.step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (bus.halt_instr)    state_d = ST_HALTED;
        else if (bus.halt_req) state_d = ST_IDLE;
      end
      ST_STEP:   state_d = bus.halt_instr ? ST_HALTED : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  hazard_detect #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_hazard (
    .mem_read   (bus.ex_mem_read),
    .ex_rt_addr (bus.ex_rt_addr),
    .id_rs_addr (bus.id_rs_addr),
    .id_rt_addr (bus.id_rt_addr),
    .hazard     (hazard)
  );

  assign advance = (state_q == ST_RUN) || (state_q == ST_STEP);
  // a taken branch squashes the stalled instruction anyway, so it wins
  assign stall   = advance && hazard && !bus.branch_taken;

  assign bus.pc_enable = advance && !stall;
  assign bus.state     = state_q;

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    localparam bit IS_IFID  = (k == IF_ID);
    localparam bit IS_IDEX  = (k == ID_EX);
    localparam bit WRONG_PATH = (k < BRANCH_STAGE);
    assign bus.stage_enable[k] = advance && !(stall && IS_IFID);
    assign bus.stage_flush[k]  = advance &&
                                 (bus.branch_taken ? WRONG_PATH : (hazard && IS_IDEX));
  end

  logic [CNT_WIDTH-1:0] cycle_q, stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (advance && (cycle_q != '1)) cycle_q <= cycle_q + 1'b1;
      if (stall   && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.stall_count = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush/run controller for the parametrised N-stage MIPS pipeline.
- Sequences execution in run, single-step and halt modes for the debug unit.
- Detects load-use hazards and issues bubbles. Squashes wrong-path instructions on a taken branch.
- Drives the PC enable and the per-pipeline-register enable/flush lines, and keeps cycle and stall counters.

Parameters:
- NUM_STAGES, 5, pipeline depth (>=4); there are NUM_STAGES-1 pipeline registers, index 0 = IF/ID.
- BRANCH_STAGE, 3, stage index where branch_taken is resolved (1..NUM_STAGES-2; default MEM).
- REG_ADDR_BITS, 5, register-file address width.
- CNT_WIDTH, 32, width of cycle_count and stall_count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run_req  in  1  start continuous execution.
- step_req  in  1  execute exactly one clock of pipeline advance.
- halt_req  in  1  external stop request.
- halt_instr  in  1  HALT opcode has reached writeback.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt_addr  in  REG_ADDR_BITS  load destination in EX.
- id_rs_addr  in  REG_ADDR_BITS  rs of instruction in ID.
- id_rt_addr  in  REG_ADDR_BITS  rt of instruction in ID.
- branch_taken  in  1  taken branch resolved in BRANCH_STAGE.
- pc_enable  out  1  PC register update enable.
- stage_enable  out  NUM_STAGES-1  per-pipeline-register load enable.
- stage_flush  out  NUM_STAGES-1  per-pipeline-register synchronous clear (bubble).
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
- cycle_count  out  CNT_WIDTH  advance cycles since reset.
- stall_count  out  CNT_WIDTH  hazard-stall cycles since reset.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; cycle_count=0; stall_count=0.
  - pc_enable=0; stage_enable=0; stage_flush=0.
  - A mid-operation reset abandons any RUN or STEP immediately.
- Registered FSM, transitions evaluated at the rising edge:
  - IDLE: run_req -> RUN. Else step_req -> STEP. Run wins when both are asserted.
  - RUN: halt_instr -> HALTED. Else halt_req -> IDLE. halt_instr has priority.
  - STEP: lasts exactly one cycle. halt_instr -> HALTED, else -> IDLE. run_req and step_req are ignored while in STEP.
  - HALTED: sticky. Only reset exits.
- advance = (state==RUN) or (state==STEP).
- Outputs are combinational from state and inputs; zero latency within the cycle.
- Not advancing: pc_enable=0; all stage_enable=0; all stage_flush=0. The pipeline is frozen.
- hazard = ex_mem_read and ex_rt_addr!=0 and (ex_rt_addr==id_rs_addr or ex_rt_addr==id_rt_addr).
- Normal advance (no hazard, no branch): pc_enable=1; all stage_enable=1; stage_flush=0.
- Advance with hazard and no branch:
  - pc_enable=0; stage_enable[0]=0 (IF/ID holds).
  - stage_flush[1]=1 (bubble into ID/EX).
  - stage_enable[k]=1 for k>=1.
- Advance with branch_taken (overrides hazard):
  - pc_enable=1; all stage_enable=1.
  - stage_flush[k]=1 for k=0..BRANCH_STAGE-1; other flushes 0.
- Flush is a clear, not a hold: a flushed register loads a NOP and zeroed control buses. enable=1 with flush=1 is legal; flush wins.
- Counters:
  - cycle_count increments on every advance cycle.
  - stall_count increments on advance cycles where hazard is set and branch_taken is not.
  - Both saturate at all-ones and never wrap.
- A STEP cycle with a hazard still consumes the step: one stall cycle, and stall_count increments.
- Inputs are sampled only in the cycle they are asserted; requests are not queued.

Decomposition:
- Shared package pipeline_pkg:
  - state encodings ST_IDLE, ST_RUN, ST_STEP, ST_HALTED;
  - pipeline-register index constants IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3.
- One sub-module, hazard_detect: combinational load-use compare. Parameter REG_ADDR_BITS; outputs hazard.
- The FSM, the enable/flush mask generation and the counters stay in pipeline_ctrl.

Test Plan:
- Reset, then run_req=1 for 1 cycle -> state=01; pc_enable=1; stage_enable=4'b1111; after 10 cycles cycle_count=10; reset low mid-run -> state=00, counters 0, all outputs 0 asynchronously.
- RUN with ex_mem_read=1, ex_rt_addr=5, id_rs_addr=5 for 1 cycle -> pc_enable=0; stage_enable=4'b1110; stage_flush=4'b0010; stall_count=1. Same with ex_rt_addr=0 -> no stall.
- RUN with hazard and branch_taken in the same cycle -> pc_enable=1; stage_flush=4'b0111; stall_count unchanged.
- From IDLE, three step_req pulses separated by idle cycles -> each gives exactly one advance cycle; state 10 then 00; cycle_count=3. A simultaneous run_req and step_req -> state=01.
- RUN, halt_instr=1 together with halt_req=1 -> HALTED (11), outputs frozen at 0. A later run_req or step_req -> no change until reset.
- CNT_WIDTH=4, run 20 cycles -> cycle_count saturates at 15.
